// File: rtl/ring_fifo.sv
// Ring-buffer FIFO with registered status, optional overwrite-oldest on full.
// Optional statistics (drop_count, high_water) enabled by `define RING_FIFO_STATS_EN.
module ring_fifo #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned BUFFER_DEPTH      = 16,
  parameter int unsigned ALMOST_FULL_LEVEL = BUFFER_DEPTH - 2,
  parameter int unsigned OVERWRITE_ON_FULL = 0
) (
  input  logic                                clk,
  input  logic                                res_n,
  input  logic                                flush,
  input  logic [DATA_WIDTH-1:0]               data_in,
  input  logic                                data_in_valid,
  output logic                                full,
  output logic                                almost_full,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]   level,
  output logic [DATA_WIDTH-1:0]               data_out,
  output logic                                data_out_valid,
  input  logic                                recv_busy,
  output logic                                overflow
`ifdef RING_FIFO_STATS_EN
  ,
  output logic [15:0]                         drop_count,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]   high_water
`endif
);

  localparam int unsigned LW = $clog2(BUFFER_DEPTH + 1);
  localparam int unsigned PW = $clog2(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [LW-1:0]         level_nxt;
  logic                  rd_en_c, wr_en_c, drop_c;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(BUFFER_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state: flush wins; a full write without a read either drops the new
  // word or (overwrite mode) evicts the oldest by advancing both pointers.
  always_comb begin
    rd_en_c    = 1'b0;
    wr_en_c    = 1'b0;
    drop_c     = 1'b0;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    level_nxt  = level;
    if (flush) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      level_nxt  = '0;
    end else begin
      rd_en_c = (level != '0) && !recv_busy;
      if (data_in_valid) begin
        if (!full || rd_en_c) begin
          wr_en_c = 1'b1;
        end else begin
          drop_c  = 1'b1;
          wr_en_c = (OVERWRITE_ON_FULL != 0);
        end
      end
      if (rd_en_c || (drop_c && wr_en_c)) rd_ptr_nxt = next_ptr(rd_ptr);
      if (wr_en_c)                        wr_ptr_nxt = next_ptr(wr_ptr);
      if (wr_en_c && !rd_en_c && !drop_c) level_nxt = level + LW'(1);
      else if (rd_en_c && !wr_en_c)       level_nxt = level - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      level          <= '0;
      full           <= 1'b0;
      almost_full    <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      rd_ptr         <= rd_ptr_nxt;
      wr_ptr         <= wr_ptr_nxt;
      level          <= level_nxt;
      full           <= (level_nxt == LW'(BUFFER_DEPTH));
      almost_full    <= (level_nxt >= LW'(ALMOST_FULL_LEVEL));
      data_out_valid <= rd_en_c;
      overflow       <= drop_c;
      if (rd_en_c) data_out <= mem[rd_ptr];
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr] <= data_in;
  end

`ifdef RING_FIFO_STATS_EN
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      drop_count <= '0;
      high_water <= '0;
    end else if (flush) begin
      drop_count <= '0;
      high_water <= '0;
    end else begin
      if (drop_c && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      if (level_nxt > high_water)             high_water <= level_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ring_fifo.sv
// Scoreboard bench for ring_fifo: two instances (drop-new depth 4, overwrite depth 5)
// driven identically and checked against a contents-list reference model.
module tb_ring_fifo;

  logic       clk = 1'b0;
  logic       res_n;
  logic       flush;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       recv_busy;

  logic       full0, af0, dov0, ovf0, full1, af1, dov1, ovf1;
  logic [2:0] lvl0, lvl1;
  logic [7:0] dout0, dout1;
`ifdef RING_FIFO_STATS_EN
  logic [15:0] dc0, dc1;
  logic [2:0]  hw0, hw1;
`endif

  always #5 clk = ~clk;

  ring_fifo #(.DATA_WIDTH(8), .BUFFER_DEPTH(4), .ALMOST_FULL_LEVEL(2), .OVERWRITE_ON_FULL(0)) u_drop (
    .clk(clk), .res_n(res_n), .flush(flush), .data_in(data_in), .data_in_valid(data_in_valid),
    .full(full0), .almost_full(af0), .level(lvl0), .data_out(dout0), .data_out_valid(dov0),
    .recv_busy(recv_busy), .overflow(ovf0)
`ifdef RING_FIFO_STATS_EN
    , .drop_count(dc0), .high_water(hw0)
`endif
  );

  ring_fifo #(.DATA_WIDTH(8), .BUFFER_DEPTH(5), .ALMOST_FULL_LEVEL(3), .OVERWRITE_ON_FULL(1)) u_ovw (
    .clk(clk), .res_n(res_n), .flush(flush), .data_in(data_in), .data_in_valid(data_in_valid),
    .full(full1), .almost_full(af1), .level(lvl1), .data_out(dout1), .data_out_valid(dov1),
    .recv_busy(recv_busy), .overflow(ovf1)
`ifdef RING_FIFO_STATS_EN
    , .drop_count(dc1), .high_water(hw1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  int depth_of [2] = '{4, 5};
  int af_of    [2] = '{2, 3};
  int ovw_of   [2] = '{0, 1};

  // Reference model: ordered contents list per instance, oldest at index 0.
  bit [7:0] mc [2][8];
  int       mn [2];
  bit [7:0] exp0 [$];
  bit [7:0] exp1 [$];
  int       exp_dv  [2];
  int       exp_ovf [2];
  int       exp_lvl [2];
  int       drops   [2];
  int       hwm     [2];
  bit [7:0] last_out [2];

  function automatic void chk(input string name, input int k, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[inst%0d] @%0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endfunction

  function automatic void m_pop(input int k);
    for (int i = 0; i < 7; i++) mc[k][i] = mc[k][i+1];
    mn[k]--;
  endfunction

  function automatic void m_push(input int k, input bit [7:0] d);
    mc[k][mn[k]] = d;
    mn[k]++;
  endfunction

  function automatic void model_step(input int k, input bit dv, input bit [7:0] d,
                                     input bit busy, input bit fl);
    bit rd;
    bit ov;
    ov = 1'b0;
    rd = !fl && (mn[k] > 0) && !busy;
    if (fl) begin
      mn[k]    = 0;
      drops[k] = 0;
      hwm[k]   = 0;
    end else begin
      if (rd) begin
        if (k == 0) exp0.push_back(mc[k][0]);
        else        exp1.push_back(mc[k][0]);
        m_pop(k);
      end
      if (dv) begin
        if (mn[k] < depth_of[k]) m_push(k, d);
        else begin
          ov = 1'b1;
          if (ovw_of[k] != 0) begin
            m_pop(k);
            m_push(k, d);
          end
        end
      end
      if (ov && drops[k] < 65535) drops[k]++;
      if (mn[k] > hwm[k]) hwm[k] = mn[k];
    end
    exp_dv[k]  = int'(rd);
    exp_ovf[k] = int'(ov);
    exp_lvl[k] = mn[k];
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0; exp_dv[k] = 0; exp_ovf[k] = 0; exp_lvl[k] = 0;
      drops[k] = 0; hwm[k] = 0; last_out[k] = 8'h00;
    end
    exp0.delete();
    exp1.delete();
  endfunction

  function automatic void check_inst(input int k, input logic dov, input logic [7:0] dout,
                                     input logic [2:0] lvl, input logic fl, input logic af,
                                     input logic ovf);
    bit [7:0] w;
    chk("data_out_valid", k, int'(dov), exp_dv[k]);
    if (dov === 1'b1) begin
      if ((k == 0 && exp0.size() == 0) || (k == 1 && exp1.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL data_unexpected[inst%0d] @%0t: got %0h, expected no word", k, $time, dout);
      end else begin
        w = (k == 0) ? exp0.pop_front() : exp1.pop_front();
        chk("data_out", k, int'(dout), int'(w));
        last_out[k] = w;
      end
    end else begin
      chk("data_out_hold", k, int'(dout), int'(last_out[k]));
    end
    chk("level", k, int'(lvl), exp_lvl[k]);
    chk("full", k, int'(fl), int'(exp_lvl[k] == depth_of[k]));
    chk("almost_full", k, int'(af), int'(exp_lvl[k] >= af_of[k]));
    chk("overflow", k, int'(ovf), exp_ovf[k]);
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    check_inst(0, dov0, dout0, lvl0, full0, af0, ovf0);
    check_inst(1, dov1, dout1, lvl1, full1, af1, ovf1);
`ifdef RING_FIFO_STATS_EN
    chk("drop_count", 0, int'(dc0), drops[0]);
    chk("drop_count", 1, int'(dc1), drops[1]);
    chk("high_water", 0, int'(hw0), hwm[0]);
    chk("high_water", 1, int'(hw1), hwm[1]);
`endif
  end

  task automatic drive(input bit dv, input bit [7:0] d, input bit busy, input bit fl);
    data_in_valid = dv;
    data_in       = d;
    recv_busy     = busy;
    flush         = fl;
    if (res_n) begin
      model_step(0, dv, d, busy, fl);
      model_step(1, dv, d, busy, fl);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic async_reset();
    #1;
    res_n = 1'b0;
    #1;
    chk("rst_level", 0, int'(lvl0), 0);
    chk("rst_level", 1, int'(lvl1), 0);
    chk("rst_full", 0, int'(full0), 0);
    chk("rst_almost_full", 1, int'(af1), 0);
    chk("rst_valid", 0, int'(dov0), 0);
    chk("rst_overflow", 1, int'(ovf1), 0);
    chk("rst_data_out", 0, int'(dout0), 0);
    chk("rst_data_out", 1, int'(dout1), 0);
`ifdef RING_FIFO_STATS_EN
    chk("rst_drop_count", 0, int'(dc0), 0);
    chk("rst_high_water", 1, int'(hw1), 0);
`endif
    model_reset();
    #1;
    res_n = 1'b1;
  endtask

  int busy_pct [6] = '{20, 70, 90, 10, 50, 95};

  initial begin
    res_n = 1'b0;
    flush = 1'b0;
    data_in = 8'h00;
    data_in_valid = 1'b0;
    recv_busy = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    res_n = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill while stalled, then two writes into a full FIFO, then drain.
    drive(1'b1, 8'hA0, 1'b1, 1'b0);
    drive(1'b1, 8'hB0, 1'b1, 1'b0);
    drive(1'b1, 8'hC0, 1'b1, 1'b0);
    drive(1'b1, 8'hD0, 1'b1, 1'b0);
    drive(1'b1, 8'hE0, 1'b1, 1'b0);
    drive(1'b1, 8'hF0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Streaming through an otherwise empty FIFO; wraps the pointers.
    for (int i = 0; i < 12; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Flush with a simultaneous write, then one fresh word.
    drive(1'b1, 8'h31, 1'b1, 1'b0);
    drive(1'b1, 8'h32, 1'b1, 1'b0);
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    drive(1'b1, 8'h99, 1'b1, 1'b1);
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset between edges at level 2.
    drive(1'b1, 8'h51, 1'b1, 1'b0);
    drive(1'b1, 8'h52, 1'b1, 1'b0);
    async_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h61, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Randomized traffic with varying receiver stall density.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 100; i++) begin
        drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 99) < busy_pct[p],
              $urandom_range(0, 99) < 3);
      end
    end
    for (int i = 0; i < 12; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);

    chk("leftover_words", 0, exp0.size(), 0);
    chk("leftover_words", 1, exp1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_fifo.md
RING_FIFO -- requirements
Module: ring_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each stored word.
REQ-002 Parameter BUFFER_DEPTH, default 16: number of entries; any integer >= 2; not restricted to powers of two.
REQ-003 Parameter ALMOST_FULL_LEVEL, default BUFFER_DEPTH-2: level at or above which almost_full asserts; range 1..BUFFER_DEPTH.
REQ-004 Parameter OVERWRITE_ON_FULL, default 0: 1 = a write while full discards the oldest word; 0 = the new word is discarded.
REQ-005 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-006 Port res_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port flush, input, 1: synchronous clear of the contents.
REQ-008 Port data_in, input, DATA_WIDTH: write data.
REQ-009 Port data_in_valid, input, 1: write strobe; one word per cycle while high.
REQ-010 Port full, output, 1: level == BUFFER_DEPTH, registered.
REQ-011 Port almost_full, output, 1: level >= ALMOST_FULL_LEVEL, registered.
REQ-012 Port level, output, $clog2(BUFFER_DEPTH+1): current occupancy, registered.
REQ-013 Port data_out, output, DATA_WIDTH: read data; holds its last value when not valid.
REQ-014 Port data_out_valid, output, 1: one-cycle pulse per word emitted.
REQ-015 Port recv_busy, input, 1: receiver stall; no word is emitted on an edge where it is sampled high.
REQ-016 Port overflow, output, 1: one-cycle pulse when a word is lost (either the new word or the oldest).

Function
REQ-017 Read: on each edge where level>0, recv_busy=0 and flush=0:
- data_out <= entry at read pointer;
- data_out_valid <= 1;
- read pointer advances.
- This repeats back-to-back every cycle; there is no cooldown cycle.
REQ-018 Write: on each edge where data_in_valid=1, flush=0 and (full=0 or a read occurs on the same edge):
- data_in is stored at the write pointer;
- the write pointer advances.
REQ-019 Pointers wrap from BUFFER_DEPTH-1 to 0.
REQ-020 Level update: level increments on write-only edges, decrements on read-only edges, and is unchanged when both occur.
REQ-021 Latency: a word written into an empty FIFO at edge N is emitted at edge N+1 at the earliest; data_out_valid is high during cycle N+1.
REQ-022 Write while full with no read, OVERWRITE_ON_FULL=0:
- the word is discarded;
- pointers and level are unchanged;
- overflow pulses for one cycle.
REQ-023 Write while full with no read, OVERWRITE_ON_FULL=1:
- the word is stored;
- both pointers advance;
- level stays BUFFER_DEPTH;
- overflow pulses for one cycle.
REQ-024 Write and read on the same edge while full: both proceed, level stays BUFFER_DEPTH, and overflow stays low.
REQ-025 Read while empty is impossible: data_out_valid stays 0, and data_in_valid on that edge produces no same-edge bypass.
REQ-026 Flush:
- has priority over read and write on the same edge;
- pointers and level go to 0, full and almost_full to 0;
- data_out_valid and overflow are 0 on the following cycle;
- the data_in on that edge is discarded.
REQ-027 full, almost_full and level are derived from the next-state level, so they are valid in the cycle after each edge.

Reset
REQ-028 res_n low asynchronously sets:
- pointers = 0, level = 0;
- full = 0, almost_full = 0;
- data_out_valid = 0, overflow = 0;
- data_out = 0.
REQ-029 Storage array contents are not reset.
REQ-030 Reset asserted mid-operation discards all contents; the first edge after res_n deasserts behaves as from empty.

Configuration
REQ-031 Macro RING_FIFO_STATS_EN.
- When defined: output drop_count [15:0] counts overflow pulses and saturates at 16'hFFFF; output high_water [level width] holds the maximum level reached.
- Both statistics registers are cleared by res_n and by flush.
- When undefined: neither port nor its registers exist; all other behaviour is identical.

Verification
REQ-032 DEPTH=4, recv_busy=1, write A,B,C,D on consecutive edges -> level 1,2,3,4; almost_full from level 2; full=1 after D.
REQ-033 Full FIFO, OVERWRITE_ON_FULL=0, write E with recv_busy=1 -> overflow pulses once, level=4; after recv_busy=0 the output is A,B,C,D on 4 consecutive cycles.
REQ-034 Same stimulus with OVERWRITE_ON_FULL=1 -> overflow pulses once; output is B,C,D,E.
REQ-035 DEPTH=5 (non-power of two), recv_busy=0, continuous writes of 0..11 -> each value emitted exactly one cycle after its write, in order; level stays at most 1; pointer wrap is exercised.
REQ-036 Level 3 with flush and data_in_valid high on the same edge -> level=0 and no data_out_valid next cycle; a subsequent write emits only the new word.
REQ-037 res_n pulsed low asynchronously between edges while at level 2 -> all outputs clear immediately; with RING_FIFO_STATS_EN defined, drop_count=0 and high_water=0.
